// File: rtl/snoop_requester.sv
// snoop_requester: initiator side of the snoop port on the snoopable FIFO.
// Accepts tagged snoop requests, drives a registered sdata/svalid strobe toward
// the FIFO, captures smatch LAT cycles later and returns in-order {tag, hit}
// responses. One request per cycle is sustained while responses are drained.
//
// Optional feature: define SNOOP_REQ_STATS_EN to add saturating hit/miss counters.
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   req_data_i/req_tag_i        request payload and tag
//   req_valid_i/req_ready_o     request handshake
//   sdata_o/svalid_o            registered snoop strobe toward the FIFO
//   smatch_i                    FIFO match result, valid LAT cycles after svalid_o
//   rsp_tag_o/rsp_hit_o         head response
//   rsp_valid_o/rsp_ready_i     response handshake
//   hit_cnt_o/miss_cnt_o        (SNOOP_REQ_STATS_EN only) 16-bit saturating counters
module snoop_requester #(
    parameter int unsigned DW    = 164,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DW-1:0]    req_data_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic [DW-1:0]    sdata_o,
    output logic             svalid_o,
    input  logic             smatch_i,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_hit_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i
`ifdef SNOOP_REQ_STATS_EN
    ,
    output logic [15:0]      hit_cnt_o,
    output logic [15:0]      miss_cnt_o
`endif
);

    // Queue depth covers every request that can be in flight plus the queued ones.
    localparam int unsigned Depth = LAT + 3;
    localparam int unsigned CW    = $clog2(LAT + 4);
    localparam int unsigned PW    = $clog2(Depth);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    qcnt_q, qcnt_d;
    logic             accept, pop;

    logic [DW-1:0]    sdata_q;
    logic             svalid_q;
    logic [TAG_W-1:0] stag_q;

    logic [LAT-1:0]   pv_q;
    logic [TAG_W-1:0] ptag_q [LAT];

    logic [TAG_W:0]   mem_q [Depth];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic             q_wr, q_full;

    // Credit check uses only the registered count: no path from req_valid/rsp_ready.
    assign req_ready_o = (cnt_q < CW'(Depth));
    assign accept      = req_valid_i & req_ready_o;
    assign pop         = rsp_valid_o & rsp_ready_i;

    assign q_wr        = pv_q[LAT-1];
    assign q_full      = (qcnt_q == CW'(Depth));

    assign rsp_valid_o = (qcnt_q != '0);
    assign rsp_tag_o   = mem_q[rptr_q][TAG_W:1];
    assign rsp_hit_o   = mem_q[rptr_q][0];
    assign sdata_o     = sdata_q;
    assign svalid_o    = svalid_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !accept) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        qcnt_d = qcnt_q;
        if (q_wr && !pop) begin
            qcnt_d = qcnt_q + CW'(1);
        end else if (pop && !q_wr) begin
            qcnt_d = qcnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            qcnt_q   <= '0;
            sdata_q  <= '0;
            svalid_q <= 1'b0;
            stag_q   <= '0;
            pv_q     <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                ptag_q[i] <= '0;
            end
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            qcnt_q   <= qcnt_d;
            svalid_q <= accept;
            if (accept) begin
                sdata_q <= req_data_i;
                stag_q  <= req_tag_i;
            end
            // Tag pipeline aligns each tag with the cycle its smatch is valid.
            pv_q[0]   <= svalid_q;
            ptag_q[0] <= stag_q;
            for (int i = 1; i < int'(LAT); i++) begin
                pv_q[i]   <= pv_q[i-1];
                ptag_q[i] <= ptag_q[i-1];
            end
            if (q_wr) begin
                mem_q[wptr_q] <= {ptag_q[LAT-1], smatch_i};
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
        end
    end

`ifdef SNOOP_REQ_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (q_wr) begin
            if (smatch_i) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    // The credit limit makes a write into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(q_wr && q_full));

endmodule

// File: doc/snoop_requester.md
# snoop_requester

Initiator side of the snoop port on the snoopable FIFO. Accepts tagged snoop requests over valid/ready, drives `sdata`/`svalid` toward the FIFO, samples the returned `smatch` a fixed number of cycles later, and returns an in-order `{tag, hit}` response over a second valid/ready channel. It is pipelined: one request per cycle, sustained, while the response consumer keeps up.

## Interface
- `DW`, 164, snoop data width; matches the FIFO entry width.
- `TAG_W`, 4, request tag width.
- `LAT`, 1, cycles from the `svalid` cycle to the cycle `smatch` is valid; legal range 1..8.
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `req_data`  in  DW  address/data to snoop.
- `req_tag`  in  TAG_W  request tag, returned unchanged.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high with `req_valid`.
- `sdata`  out  DW  snoop data to the FIFO, registered.
- `svalid`  out  1  snoop strobe, registered, one cycle per request.
- `smatch`  in  1  FIFO match result, valid LAT cycles after the `svalid` cycle.
- `rsp_tag`  out  TAG_W  tag of the head response.
- `rsp_hit`  out  1  captured `smatch` for that tag.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`.

## Operation
- Credit counter `cnt` (width ceil(log2(LAT+4))) tracks accepted requests whose responses have not been popped. Increment on accept, decrement on pop, hold when both or neither occur.
- `req_ready` = (`cnt` < LAT+3), decoded from registered `cnt` only. There is no combinational path from `req_valid` or `rsp_ready`.
- Issue stage: on accept, `sdata` <= `req_data` and `svalid` <= 1. Otherwise `svalid` <= 0 and `sdata` holds its value.
- Tag pipeline: a LAT-deep shift register of `{valid, tag}` is loaded from the issue stage. When the last stage's valid is high, `{tag, smatch}` is written into the response queue in that cycle. `smatch` is ignored in all other cycles.
- Response queue: circular buffer, depth LAT+3, separate read and write pointers, in order. Head drives `rsp_tag`/`rsp_hit`. `rsp_valid` is high when the queue is not empty. The credit scheme guarantees no overflow, so a write into a full queue is a design error and is asserted in simulation.
- When the queue is empty and a write occurs, `rsp_valid` rises the next cycle. There is no same-cycle bypass.
- While `rsp_valid` is high and `rsp_ready` is low, `rsp_tag`/`rsp_hit` hold stable.
- Reset values: `req_ready`=1, `svalid`=0, `sdata`=0, `rsp_valid`=0, `rsp_tag`=0, `rsp_hit`=0, `cnt`=0, all pointers and pipeline valids 0.
- Reset mid-operation clears all in-flight state immediately. Late `smatch` values from snoops issued before reset are discarded.

## Timing
- Accept in cycle t -> `svalid` high in cycle t+1 -> `smatch` sampled at the end of cycle t+1+LAT -> `rsp_valid` earliest in cycle t+2+LAT.
- Throughput: 1 request/cycle indefinitely with `rsp_ready` held high. Steady-state `cnt` = LAT+2.
- With `rsp_ready` low: exactly LAT+3 requests are accepted, then `req_ready` drops. It rises the cycle after the first pop.
- Simultaneous accept and pop when `cnt` = LAT+3 cannot occur, because `req_ready` is low in that case.

## Configuration
- `SNOOP_REQ_STATS_EN`: when defined, adds output ports `hit_cnt` and `miss_cnt` (16-bit each). Each is a saturating counter that increments when a response with hit=1 or hit=0 respectively is written into the queue. Both reset to 0 and hold at 16'hFFFF.
- Without the macro, these ports and their counters do not exist. The rest of the behaviour is identical.

## Test plan
- Reset check, LAT=1: after `rstn` release -> `req_ready`=1, `svalid`=0, `rsp_valid`=0; with no stimulus, outputs stay at reset values for 20 cycles.
- Single request, LAT=1: tag 4'h5 accepted in cycle 0 with `smatch`=1 in cycle 2 -> `svalid` high only in cycle 1 with `sdata`=`req_data`; `rsp_valid` high in cycle 3 with `rsp_tag`=5, `rsp_hit`=1.
- Streaming, LAT=3: tags 0..15 back-to-back, `smatch` alternating 1,0, `rsp_ready`=1 -> no `req_ready` bubble; responses arrive in order with alternating hits, the first in cycle 5.
- Backpressure, LAT=2: `rsp_ready`=0 -> exactly 5 requests accepted, then `req_ready`=0; `rsp_ready` pulsed once -> tag 0 popped, `req_ready`=1 in the next cycle, and no response is lost or duplicated.
- Reset mid-flight, LAT=4: 3 requests in flight, then `rstn` pulsed low, then `smatch`=1 driven -> no response ever appears, `cnt` returns to 0, and a new request completes normally.
- Stats (`SNOOP_REQ_STATS_EN` defined): 10 hits and 6 misses -> `hit_cnt`=10, `miss_cnt`=6; with the counter forced to 16'hFFFF, a further hit leaves it at 16'hFFFF.
